// File: rtl/picoblaze_cmd_decoder_pkg.sv
// Shared constants for the kcpsm6 output-port command decoder:
// keyboard codes, state bytes, status bit positions and FSM encodings.
package picoblaze_cmd_pkg;

    // Keyboard codes written by the firmware to the key port
    localparam logic [7:0] KEY_INC   = 8'h57;  // 'W'
    localparam logic [7:0] KEY_DEC   = 8'h53;  // 'S'
    localparam logic [7:0] KEY_LEFT  = 8'h41;  // 'A'
    localparam logic [7:0] KEY_RIGHT = 8'h44;  // 'D'
    localparam logic [7:0] KEY_RST   = 8'h08;  // 'r' / backspace
    localparam logic [7:0] KEY_INSTR = 8'h49;  // 'I'

    // Byte on in_port that requests the programming blink
    localparam logic [7:0] PROG_CODE  = 8'h50;
    // State bytes shown while blinking
    localparam logic [7:0] PROG_STATE = 8'h02;
    localparam logic [7:0] READ_STATE = 8'h00;

    // Bit positions inside status_data
    localparam int STAT_INSTR_BIT = 0;
    localparam int STAT_PROG_BIT  = 1;
    localparam int STAT_RST_BIT   = 2;

    // Programming alternation FSM
    typedef enum logic [1:0] {
        PROG_NORMAL = 2'd0,
        PROG_A      = 2'd1,
        PROG_B      = 2'd2
    } prog_state_e;

    // Reset stretcher FSM
    typedef enum logic {
        STR_IDLE = 1'b0,
        STR_BUSY = 1'b1
    } str_state_e;

endpackage

// File: rtl/picoblaze_cmd_decoder_if.sv
// Bus between the kcpsm6 core (master) and the command decoder (slave),
// including the decoded command/status outputs going back to the system.
interface picoblaze_cmd_decoder_if #(
    parameter int DW = 8
);
    logic [7:0]    port_id;
    logic [DW-1:0] out_port;
    logic          write_strobe;
    logic [DW-1:0] in_port;

    logic [DW-1:0] state_out;
    logic          inc;
    logic          dec;
    logic          left;
    logic          right;
    logic          instr_en;
    logic          rst_out;
    logic          prog_mode;
    logic [DW-1:0] status_data;

    modport master (
        output port_id, out_port, write_strobe, in_port,
        input  state_out, inc, dec, left, right, instr_en, rst_out,
               prog_mode, status_data
    );

    modport slave (
        input  port_id, out_port, write_strobe, in_port,
        output state_out, inc, dec, left, right, instr_en, rst_out,
               prog_mode, status_data
    );
endinterface

// File: rtl/picoblaze_cmd_decoder_stretcher.sv
// Fixed-length pulse stretcher: a trigger while idle produces an output
// that is high for exactly LEN cycles starting the cycle after the trigger.
// Triggers while busy are ignored; reset aborts a running pulse.
module pulse_stretcher
    import picoblaze_cmd_pkg::*;
#(
    parameter int LEN = 1044
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic busy_o,
    output logic out_o
);
    localparam int CNT_W = $clog2(LEN + 1);

    str_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= STR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count LEN cycles in BUSY, then fall back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STR_IDLE: begin
                if (trig_i) begin
                    state_d = STR_BUSY;
                    cnt_d   = '0;
                end
            end
            STR_BUSY: begin
                if (cnt_q == CNT_W'(LEN - 1)) begin
                    state_d = STR_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from the state register
    always_comb begin
        busy_o = (state_q == STR_BUSY);
        out_o  = (state_q == STR_BUSY);
    end

endmodule

// File: rtl/picoblaze_cmd_decoder.sv
// Output-port decoder between kcpsm6 and the stopwatch datapath.
// Key writes become one-cycle command pulses, KEY_INSTR toggles instr_en,
// KEY_RST launches a stretched datapath reset, and state writes drive the
// FSM state byte, overridden by a PROG/READ blink while in_port==PROG_CODE.
module picoblaze_cmd_decoder
    import picoblaze_cmd_pkg::*;
#(
    parameter int         DW            = 8,
    parameter logic [7:0] KEY_PORT_ID   = 8'h01,
    parameter logic [7:0] STATE_PORT_ID = 8'h02,
    parameter int         RST_CYCLES    = 1044,
    parameter int         ALT_CYCLES    = 74
) (
    input  logic                    clk,
    input  logic                    reset,
    picoblaze_cmd_decoder_if.slave  bus
);
    localparam int ALT_W = $clog2(ALT_CYCLES + 1);

    localparam logic [DW-1:0] K_INC   = DW'(KEY_INC);
    localparam logic [DW-1:0] K_DEC   = DW'(KEY_DEC);
    localparam logic [DW-1:0] K_LEFT  = DW'(KEY_LEFT);
    localparam logic [DW-1:0] K_RIGHT = DW'(KEY_RIGHT);
    localparam logic [DW-1:0] K_RST   = DW'(KEY_RST);
    localparam logic [DW-1:0] K_INSTR = DW'(KEY_INSTR);
    localparam logic [DW-1:0] K_PROG  = DW'(PROG_CODE);

    logic key_wr;
    logic state_wr;
    logic code_seen;

    assign key_wr    = bus.write_strobe && (bus.port_id == KEY_PORT_ID);
    assign state_wr  = bus.write_strobe && (bus.port_id == STATE_PORT_ID);
    assign code_seen = (bus.in_port == K_PROG);

    // ---------------- key decode ----------------
    logic inc_q, dec_q, left_q, right_q, instr_en_q;
    logic inc_d, dec_d, left_d, right_d, instr_en_d;

    // Next values of the command pulses and the instruction toggle
    always_comb begin
        inc_d      = key_wr && (bus.out_port == K_INC);
        dec_d      = key_wr && (bus.out_port == K_DEC);
        left_d     = key_wr && (bus.out_port == K_LEFT);
        right_d    = key_wr && (bus.out_port == K_RIGHT);
        instr_en_d = instr_en_q ^ (key_wr && (bus.out_port == K_INSTR));
    end

    // Command pulse and toggle registers
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            instr_en_q <= 1'b0;
        end else begin
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            left_q     <= left_d;
            right_q    <= right_d;
            instr_en_q <= instr_en_d;
        end
    end

    // ---------------- datapath reset stretcher ----------------
    logic rst_out_w;
    logic rst_busy_w;

    pulse_stretcher #(
        .LEN (RST_CYCLES)
    ) u_rst_stretch (
        .clk_i  (clk),
        .rst_i  (reset),
        .trig_i (key_wr && (bus.out_port == K_RST)),
        .busy_o (rst_busy_w),
        .out_o  (rst_out_w)
    );

    // ---------------- state byte / programming blink ----------------
    prog_state_e      prog_q, prog_d;
    logic [ALT_W-1:0] alt_cnt_q, alt_cnt_d;
    logic [DW-1:0]    saved_q, saved_d;
    logic             prog_mode_q;
    logic [DW-1:0]    state_out_w;

    // State register for the blink FSM, phase counter and saved state byte
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_q      <= PROG_NORMAL;
            alt_cnt_q   <= '0;
            saved_q     <= DW'(READ_STATE);
            prog_mode_q <= 1'b0;
        end else begin
            prog_q      <= prog_d;
            alt_cnt_q   <= alt_cnt_d;
            saved_q     <= saved_d;
            prog_mode_q <= (prog_d != PROG_NORMAL);
        end
    end

    // Next state: enter on PROG_CODE, alternate every ALT_CYCLES, leave on any other byte
    always_comb begin
        prog_d    = prog_q;
        alt_cnt_d = alt_cnt_q;
        saved_d   = state_wr ? bus.out_port : saved_q;
        case (prog_q)
            PROG_NORMAL: begin
                if (code_seen) begin
                    prog_d    = PROG_A;
                    alt_cnt_d = '0;
                end
            end
            PROG_A, PROG_B: begin
                if (!code_seen) begin
                    prog_d    = PROG_NORMAL;
                    alt_cnt_d = '0;
                end else if (alt_cnt_q == ALT_W'(ALT_CYCLES - 1)) begin
                    prog_d    = (prog_q == PROG_A) ? PROG_B : PROG_A;
                    alt_cnt_d = '0;
                end else begin
                    alt_cnt_d = alt_cnt_q + ALT_W'(1);
                end
            end
            default: begin
                prog_d    = PROG_NORMAL;
                alt_cnt_d = '0;
            end
        endcase
    end

    // Output: blink bytes override the saved state while programming
    always_comb begin
        case (prog_q)
            PROG_A:  state_out_w = DW'(PROG_STATE);
            PROG_B:  state_out_w = DW'(READ_STATE);
            default: state_out_w = saved_q;
        endcase
    end

    // Status byte assembled only from register outputs
    logic [DW-1:0] status_w;
    always_comb begin
        status_w                 = '0;
        status_w[STAT_INSTR_BIT] = instr_en_q;
        status_w[STAT_PROG_BIT]  = prog_mode_q;
        status_w[STAT_RST_BIT]   = rst_busy_w;
    end

    assign bus.state_out   = state_out_w;
    assign bus.inc         = inc_q;
    assign bus.dec         = dec_q;
    assign bus.left        = left_q;
    assign bus.right       = right_q;
    assign bus.instr_en    = instr_en_q;
    assign bus.rst_out     = rst_out_w;
    assign bus.prog_mode   = prog_mode_q;
    assign bus.status_data = status_w;

endmodule

// File: tb/tb_picoblaze_cmd_decoder.sv
module tb_picoblaze_cmd_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    picoblaze_cmd_decoder_if #(.DW(8)) bus();

    picoblaze_cmd_decoder #(
        .DW            (8),
        .KEY_PORT_ID   (8'h01),
        .STATE_PORT_ID (8'h02),
        .RST_CYCLES    (1044),
        .ALT_CYCLES    (74)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
        logic       ws;
        logic [7:0] inp;
        logic [7:0] st;
        logic       inc, dec, lft, rgt, instr, rst, prog;
        string      name;
    } vec_t;

    vec_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [7:0] port, input logic [7:0] data,
                                input logic ws, input logic [7:0] inp,
                                input logic [7:0] st, input logic inc, input logic dec,
                                input logic lft, input logic rgt, input logic instr,
                                input logic rst, input logic prog, input string name);
        vec_t v;
        v.port = port; v.data = data; v.ws = ws; v.inp = inp;
        v.st = st; v.inc = inc; v.dec = dec; v.lft = lft; v.rgt = rgt;
        v.instr = instr; v.rst = rst; v.prog = prog; v.name = name;
        return v;
    endfunction

    task automatic check(input vec_t e);
        logic [22:0] act, req;
        act = {bus.state_out, bus.inc, bus.dec, bus.left, bus.right,
               bus.instr_en, bus.rst_out, bus.prog_mode, bus.status_data};
        req = {e.st, e.inc, e.dec, e.lft, e.rgt, e.instr, e.rst, e.prog,
               {5'b0, e.rst, e.prog, e.instr}};
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got state/inc/dec/l/r/instr/rst/prog/status=%h required %h",
                     e.name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        bus.port_id      = v.port;
        bus.out_port     = v.data;
        bus.write_strobe = v.ws;
        bus.in_port      = v.inp;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sbq.pop_front();
            check(e);
        end
    endtask

    vec_t tbl[17];

    initial begin
        bus.port_id = 8'h00; bus.out_port = 8'h00;
        bus.write_strobe = 1'b0; bus.in_port = 8'h00;

        // Table: applied from post-reset state (state 00, instr 0)
        tbl[0]  = mk(8'h01, 8'h57, 1, 8'h00, 8'h00, 1,0,0,0, 0,0,0, "key_inc");
        tbl[1]  = mk(8'h01, 8'h53, 1, 8'h00, 8'h00, 0,1,0,0, 0,0,0, "key_dec");
        tbl[2]  = mk(8'h01, 8'h41, 1, 8'h00, 8'h00, 0,0,1,0, 0,0,0, "key_left");
        tbl[3]  = mk(8'h01, 8'h44, 1, 8'h00, 8'h00, 0,0,0,1, 0,0,0, "key_right");
        tbl[4]  = mk(8'h01, 8'h99, 1, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "key_unknown");
        tbl[5]  = mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "idle");
        tbl[6]  = mk(8'h01, 8'h57, 0, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "no_strobe");
        tbl[7]  = mk(8'h03, 8'h57, 1, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "wrong_port");
        tbl[8]  = mk(8'h02, 8'h05, 1, 8'h00, 8'h05, 0,0,0,0, 0,0,0, "state_wr_05");
        tbl[9]  = mk(8'h00, 8'h00, 0, 8'h00, 8'h05, 0,0,0,0, 0,0,0, "state_hold");
        tbl[10] = mk(8'h01, 8'h49, 1, 8'h00, 8'h05, 0,0,0,0, 1,0,0, "instr_on");
        tbl[11] = mk(8'h00, 8'h00, 0, 8'h00, 8'h05, 0,0,0,0, 1,0,0, "instr_hold");
        tbl[12] = mk(8'h01, 8'h49, 1, 8'h00, 8'h05, 0,0,0,0, 0,0,0, "instr_off");
        tbl[13] = mk(8'h02, 8'h57, 1, 8'h00, 8'h57, 0,0,0,0, 0,0,0, "state_port_no_key");
        tbl[14] = mk(8'h01, 8'h57, 1, 8'h50, 8'h02, 1,0,0,0, 0,0,1, "key_and_prog_entry");
        tbl[15] = mk(8'h00, 8'h00, 0, 8'h00, 8'h57, 0,0,0,0, 0,0,0, "prog_exit_quick");
        tbl[16] = mk(8'h02, 8'h00, 1, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "state_wr_00");

        // Reset state
        reset = 1'b1;
        for (int i = 0; i < 2; i++)
            apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "reset_state"));
        reset = 1'b0;

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // instr_en: two KEY_INSTR writes 10 cycles apart
        for (int k = 0; k < 13; k++) begin
            if (k == 0 || k == 10)
                apply(mk(8'h01, 8'h49, 1, 8'h00, 8'h00, 0,0,0,0, (k < 10),0,0, "instr_toggle"));
            else
                apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, (k < 10),0,0, "instr_toggle"));
        end

        // rst_out: stretch length and retrigger immunity
        for (int k = 0; k < 1050; k++) begin
            if (k == 0 || k == 100)
                apply(mk(8'h01, 8'h08, 1, 8'h00, 8'h00, 0,0,0,0, 0,(k < 1044),0, "rst_stretch"));
            else
                apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, 0,(k < 1044),0, "rst_stretch"));
        end

        // Reset mid-pulse with instr_en set and a non-zero state byte
        apply(mk(8'h01, 8'h49, 1, 8'h00, 8'h00, 0,0,0,0, 1,0,0, "pre_rst_instr"));
        apply(mk(8'h02, 8'h05, 1, 8'h00, 8'h05, 0,0,0,0, 1,0,0, "pre_rst_state"));
        apply(mk(8'h01, 8'h08, 1, 8'h00, 8'h05, 0,0,0,0, 1,1,0, "pre_rst_pulse"));
        for (int k = 0; k < 20; k++)
            apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h05, 0,0,0,0, 1,1,0, "pre_rst_busy"));
        reset = 1'b1;
        for (int k = 0; k < 3; k++)
            apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "reset_mid_pulse"));
        reset = 1'b0;
        for (int k = 0; k < 5; k++)
            apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0, 0,0,0, "after_reset"));

        // PROG blink for 300 cycles with a state write in the middle
        for (int k = 0; k < 300; k++) begin
            logic [7:0] s;
            s = ((k / 74) % 2 == 0) ? 8'h02 : 8'h00;
            if (k == 100)
                apply(mk(8'h02, 8'h07, 1, 8'h50, s, 0,0,0,0, 0,0,1, "prog_blink_wr"));
            else
                apply(mk(8'h00, 8'h00, 0, 8'h50, s, 0,0,0,0, 0,0,1, "prog_blink"));
        end
        apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h07, 0,0,0,0, 0,0,0, "prog_exit_a"));

        // Second entry, leave while in the READ phase
        for (int k = 0; k < 80; k++)
            apply(mk(8'h00, 8'h00, 0, 8'h50, (k < 74) ? 8'h02 : 8'h00, 0,0,0,0, 0,0,1, "prog_blink2"));
        apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h07, 0,0,0,0, 0,0,0, "prog_exit_b"));
        apply(mk(8'h00, 8'h00, 0, 8'h00, 8'h07, 0,0,0,0, 0,0,0, "final_idle"));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
